alu_reservation_station: RTL and testbench
==========================================

Name: alu_reservation_station

Overview:
- Tomasulo reservation-station bank for the integer ALU.
- Sits between the instruction issuer and the CDB arbiter.
- Accepts issued ops with operands given either as values or as producer tags, and snoops the CDB to resolve pending operands.
- Executes one ready entry at a time on an internal 64-bit ALU and holds the result towards the CDB arbiter until granted (retire).

Parameters:
- XLEN, 64: operand/result width.
- DEPTH, 4: number of station entries.
- TAG_W, 3: width of station tags / cdb_rs_id.
- TAG_BASE, 0: tag of entry 0; entry i has tag TAG_BASE+i. TAG_BASE+DEPTH must be at most 2^TAG_W.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- issue_valid  in  1  issuer presents an op.
- issue_ready  out  1  at least one entry free.
- issue_op  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SLT (signed).
- issue_src1_ready  in  1  1: src1_value valid; 0: wait on src1_tag.
- issue_src1_tag  in  TAG_W  producer tag for src1.
- issue_src1_value  in  XLEN  src1 operand.
- issue_src2_ready, issue_src2_tag, issue_src2_value: same as src1 for the second operand.
- issue_tag  out  TAG_W  tag of the entry being allocated; meaningful when issue_valid&&issue_ready.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_rs_id  in  TAG_W  broadcasting station tag.
- cdb_result  in  XLEN  broadcast value.
- result_valid  out  1  result held for the CDB arbiter.
- result_rs_id  out  TAG_W  tag of the held result.
- result  out  XLEN  held result.
- retire  in  1  arbiter grant; this result is on the CDB this cycle.
- busy  out  DEPTH  per-entry occupancy.

Behaviour:
- Reset (rst low, async): all entries free; busy=0; FSM=IDLE; result_valid=0; result_rs_id=0; result=0. issue_ready=1 once reset deasserts. A held result is discarded on reset mid-operation.
- Entry state: busy, executing, op, r1/q1/v1, r2/q2/v2.

Allocation:
- issue_ready = OR of ~busy. Combinational from registered state only.
- The lowest-index free entry is allocated; issue_tag = TAG_BASE + that index.
- On handshake, the entry captures op and both sources.
- Same-cycle bypass: a source with ready=0 whose tag matches cdb_rs_id while cdb_valid=1 is stored ready with cdb_result.

CDB snoop:
- Every cycle, each busy entry with rX=0 and qX==cdb_rs_id while cdb_valid=1 sets rX=1 and vX=cdb_result.
- Both sources may match the same broadcast.

FSM IDLE:
- Select the lowest-index busy, non-executing entry with r1&&r2 (registered state; a snoop this cycle makes the entry eligible next cycle).
- If found: compute the ALU result, register result, result_rs_id and the entry index, mark the entry executing, and go to HOLD. result_valid=1 on the next cycle.
- Latency: operands ready at cycle t gives result_valid at t+1.

FSM HOLD:
- result_valid=1; result and result_rs_id held stable until retire.
- On retire=1: the entry is freed at the clock edge; result_valid=0 next cycle; FSM goes to IDLE. The next dispatch is no earlier than the cycle after.
- retire while IDLE is ignored.

ALU:
- ADD/SUB wrap modulo 2^XLEN.
- SLL/SRL shift by src2[5:0].
- SLT yields 1 or 0 on a signed compare, zero-extended.

Simultaneous events:
- issue and retire in the same cycle: the retiring entry is not allocatable that cycle.
- An entry issued in the retire cycle waiting on result_rs_id captures via bypass, because the result is on the CDB.
- An own-tag broadcast wakes other entries normally.
- All entries busy: issue_ready=0; issue_valid is ignored with no state change.

Test Plan:
- Reset, then issue ADD src1=5, src2=7, both ready → issue_tag=0, busy=0001, result_valid=1 two cycles after issue with result=12, rs_id=0. Hold until retire pulses, then result_valid=0 and busy=0000.
- Issue SUB src1 value 3, src2 waiting tag 5. Two cycles later, cdb_valid with rs_id=5 and result=10 → result_valid one cycle after capture; result=0xFFFF_FFFF_FFFF_FFF9.
- Issue src1 waiting tag 6 in the same cycle that cdb_valid carries rs_id=6, result=0x40 (bypass); op SRL, src2=4 → result=0x4.
- Fill 4 entries with operands pending → issue_ready=0 and a fifth issue_valid is ignored. Broadcast the awaited tag → entries execute lowest-index first, one per retire; entries free in order 0,1,2,3.
- Hold a result with retire low for 10 cycles → result and rs_id stable and no second dispatch. Assert rst low mid-hold → result_valid=0 and busy=0 immediately.
- SLT with src1=-1, src2=1 → result=1. SLL of 1 by src2=0x41 → result=2 (shift amount 1).

Source files
------------

// File: rtl/alu_reservation_station.sv
// Integer-ALU reservation station bank: issue with CDB snoop/bypass, one op executed at a time, result held until retire.
// Latency: both operands ready at cycle t gives result_valid at t+1; backpressure: issue_ready low when full, result held until retire.
module alu_reservation_station #(
  parameter int XLEN     = 64,
  parameter int DEPTH    = 4,
  parameter int TAG_W    = 3,
  parameter int TAG_BASE = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               issue_valid,
  output logic               issue_ready,
  input  logic [2:0]         issue_op,
  input  logic               issue_src1_ready,
  input  logic [TAG_W-1:0]   issue_src1_tag,
  input  logic [XLEN-1:0]    issue_src1_value,
  input  logic               issue_src2_ready,
  input  logic [TAG_W-1:0]   issue_src2_tag,
  input  logic [XLEN-1:0]    issue_src2_value,
  output logic [TAG_W-1:0]   issue_tag,
  input  logic               cdb_valid,
  input  logic [TAG_W-1:0]   cdb_rs_id,
  input  logic [XLEN-1:0]    cdb_result,
  output logic               result_valid,
  output logic [TAG_W-1:0]   result_rs_id,
  output logic [XLEN-1:0]    result,
  input  logic               retire,
  output logic [DEPTH-1:0]   busy
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t             state_q, state_d;
  logic [DEPTH-1:0]   busy_q, busy_d, exec_q, exec_d;
  logic [DEPTH-1:0]   r1_q, r1_d, r2_q, r2_d;
  logic [2:0]         op_q [DEPTH];
  logic [2:0]         op_d [DEPTH];
  logic [TAG_W-1:0]   q1_q [DEPTH];
  logic [TAG_W-1:0]   q1_d [DEPTH];
  logic [TAG_W-1:0]   q2_q [DEPTH];
  logic [TAG_W-1:0]   q2_d [DEPTH];
  logic [XLEN-1:0]    v1_q [DEPTH];
  logic [XLEN-1:0]    v1_d [DEPTH];
  logic [XLEN-1:0]    v2_q [DEPTH];
  logic [XLEN-1:0]    v2_d [DEPTH];
  logic [XLEN-1:0]    result_q, result_d;
  logic [TAG_W-1:0]   rs_id_q, rs_id_d;
  logic [IDX_W-1:0]   hold_idx_q, hold_idx_d;

  logic               alloc_found, sel_found;
  logic [IDX_W-1:0]   alloc_idx, sel_idx;

  function automatic logic [XLEN-1:0] alu_f(input logic [2:0] op,
                                            input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    r = '0;
    case (op)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = a << b[5:0];
      3'd6: r = a >> b[5:0];
      default: r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
    endcase
    return r;
  endfunction

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    exec_d     = exec_q;
    r1_d       = r1_q;
    r2_d       = r2_q;
    op_d       = op_q;
    q1_d       = q1_q;
    q2_d       = q2_q;
    v1_d       = v1_q;
    v2_d       = v2_q;
    result_d   = result_q;
    rs_id_d    = rs_id_q;
    hold_idx_d = hold_idx_q;

    // Downward scans so the lowest index wins.
    alloc_found = 1'b0;
    alloc_idx   = '0;
    sel_found   = 1'b0;
    sel_idx     = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        alloc_found = 1'b1;
        alloc_idx   = IDX_W'(i);
      end
      if (busy_q[i] && !exec_q[i] && r1_q[i] && r2_q[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end

    for (int i = 0; i < DEPTH; i++) begin
      if (busy_q[i] && cdb_valid && !r1_q[i] && (q1_q[i] == cdb_rs_id)) begin
        r1_d[i] = 1'b1;
        v1_d[i] = cdb_result;
      end
      if (busy_q[i] && cdb_valid && !r2_q[i] && (q2_q[i] == cdb_rs_id)) begin
        r2_d[i] = 1'b1;
        v2_d[i] = cdb_result;
      end
    end

    case (state_q)
      IDLE: begin
        if (sel_found) begin
          result_d        = alu_f(op_q[sel_idx], v1_q[sel_idx], v2_q[sel_idx]);
          rs_id_d         = TAG_W'(TAG_BASE) + TAG_W'(sel_idx);
          hold_idx_d      = sel_idx;
          exec_d[sel_idx] = 1'b1;
          state_d         = HOLD;
        end
      end
      default: begin
        if (retire) begin
          busy_d[hold_idx_q] = 1'b0;
          exec_d[hold_idx_q] = 1'b0;
          state_d            = IDLE;
        end
      end
    endcase

    // The retiring entry is still busy in registered state, so it cannot be the one allocated here.
    if (issue_valid && alloc_found) begin
      busy_d[alloc_idx] = 1'b1;
      exec_d[alloc_idx] = 1'b0;
      op_d[alloc_idx]   = issue_op;
      q1_d[alloc_idx]   = issue_src1_tag;
      q2_d[alloc_idx]   = issue_src2_tag;
      r1_d[alloc_idx]   = issue_src1_ready || (cdb_valid && (issue_src1_tag == cdb_rs_id));
      r2_d[alloc_idx]   = issue_src2_ready || (cdb_valid && (issue_src2_tag == cdb_rs_id));
      v1_d[alloc_idx]   = issue_src1_ready ? issue_src1_value : cdb_result;
      v2_d[alloc_idx]   = issue_src2_ready ? issue_src2_value : cdb_result;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      busy_q     <= '0;
      exec_q     <= '0;
      r1_q       <= '0;
      r2_q       <= '0;
      result_q   <= '0;
      rs_id_q    <= '0;
      hold_idx_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i] <= '0;
        q1_q[i] <= '0;
        q2_q[i] <= '0;
        v1_q[i] <= '0;
        v2_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      exec_q     <= exec_d;
      r1_q       <= r1_d;
      r2_q       <= r2_d;
      result_q   <= result_d;
      rs_id_q    <= rs_id_d;
      hold_idx_q <= hold_idx_d;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i] <= op_d[i];
        q1_q[i] <= q1_d[i];
        q2_q[i] <= q2_d[i];
        v1_q[i] <= v1_d[i];
        v2_q[i] <= v2_d[i];
      end
    end
  end

  assign issue_ready  = alloc_found;
  assign issue_tag    = TAG_W'(TAG_BASE) + TAG_W'(alloc_idx);
  assign result_valid = (state_q == HOLD);
  assign result_rs_id = rs_id_q;
  assign result       = result_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed stimulus for alu_reservation_station; expected results are queued at issue and
// matched by a monitor whenever a new result is presented.
module tb_alu_reservation_station;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic [2:0]  issue_op = '0;
  logic        issue_src1_ready = 1'b0;
  logic [2:0]  issue_src1_tag = '0;
  logic [63:0] issue_src1_value = '0;
  logic        issue_src2_ready = 1'b0;
  logic [2:0]  issue_src2_tag = '0;
  logic [63:0] issue_src2_value = '0;
  logic [2:0]  issue_tag;
  logic        cdb_valid = 1'b0;
  logic [2:0]  cdb_rs_id = '0;
  logic [63:0] cdb_result = '0;
  logic        result_valid;
  logic [2:0]  result_rs_id;
  logic [63:0] result;
  logic        retire = 1'b0;
  logic [3:0]  busy;

  typedef struct packed {
    logic [2:0]  id;
    logic [63:0] val;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  logic prev_vld = 1'b0;

  alu_reservation_station #(.XLEN(64), .DEPTH(4), .TAG_W(3), .TAG_BASE(0)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_src1_ready(issue_src1_ready), .issue_src1_tag(issue_src1_tag),
    .issue_src1_value(issue_src1_value),
    .issue_src2_ready(issue_src2_ready), .issue_src2_tag(issue_src2_tag),
    .issue_src2_value(issue_src2_value),
    .issue_tag(issue_tag),
    .cdb_valid(cdb_valid), .cdb_rs_id(cdb_rs_id), .cdb_result(cdb_result),
    .result_valid(result_valid), .result_rs_id(result_rs_id), .result(result),
    .retire(retire), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: each newly presented result is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      prev_vld = 1'b0;
    end else begin
      if (result_valid && !prev_vld) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got id=%0d val=%h expected none", result_rs_id, result);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_rs_id", 64'(result_rs_id), 64'(e.id));
          chk("sb_result", result, e.val);
        end
      end
      prev_vld = result_valid;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] id, input logic [63:0] val);
    exp_t e;
    e.id  = id;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic do_issue(input logic [2:0] op,
                          input logic r1, input logic [2:0] t1, input logic [63:0] v1,
                          input logic r2, input logic [2:0] t2, input logic [63:0] v2,
                          input logic [2:0] exp_tag);
    issue_valid      = 1'b1;
    issue_op         = op;
    issue_src1_ready = r1;
    issue_src1_tag   = t1;
    issue_src1_value = v1;
    issue_src2_ready = r2;
    issue_src2_tag   = t2;
    issue_src2_value = v2;
    #1;
    chk("issue_ready", 64'(issue_ready), 64'd1);
    chk("issue_tag", 64'(issue_tag), 64'(exp_tag));
    cyc();
    issue_valid = 1'b0;
  endtask

  task automatic do_retire();
    retire = 1'b1;
    cyc();
    retire = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!result_valid && n < 20) begin
      cyc();
      n++;
    end
    checks++;
    if (!result_valid) begin
      errors++;
      $display("FAIL %s_timeout: got result_valid=0 expected 1 within 20 cycles", name);
    end
  endtask

  logic [2:0]  fill_op  [4] = '{3'd0, 3'd1, 3'd4, 3'd3};
  logic [63:0] fill_v2  [4] = '{64'h1, 64'h2, 64'hFF, 64'h100};
  logic [63:0] fill_exp [4] = '{64'h1001, 64'hFFE, 64'h10FF, 64'h1100};

  initial begin
    logic [3:0] exp_busy;
    #12;
    chk("reset_result_valid", 64'(result_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_result", result, 64'd0);
    chk("reset_rs_id", 64'(result_rs_id), 64'd0);
    cyc();
    rst = 1'b1;
    #1;
    chk("ready_after_reset", 64'(issue_ready), 64'd1);

    // ADD 5+7
    push(3'd0, 64'd12);
    do_issue(3'd0, 1'b1, 3'd0, 64'd5, 1'b1, 3'd0, 64'd7, 3'd0);
    chk("add_busy", 64'(busy), 64'h1);
    chk("add_not_yet_valid", 64'(result_valid), 64'd0);
    cyc();
    chk("add_valid_t2", 64'(result_valid), 64'd1);
    cyc();
    cyc();
    chk("add_still_held", 64'(result_valid), 64'd1);
    do_retire();
    chk("add_retired_valid", 64'(result_valid), 64'd0);
    chk("add_retired_busy", 64'(busy), 64'h0);

    // SUB 3 - (tag 5 -> 10)
    push(3'd0, 64'hFFFF_FFFF_FFFF_FFF9);
    do_issue(3'd1, 1'b1, 3'd0, 64'd3, 1'b0, 3'd5, 64'd0, 3'd0);
    cyc();
    cyc();
    cdb_valid = 1'b1; cdb_rs_id = 3'd5; cdb_result = 64'd10;
    cyc();
    cdb_valid = 1'b0;
    chk("sub_wait_valid", 64'(result_valid), 64'd0);
    cyc();
    chk("sub_valid", 64'(result_valid), 64'd1);
    do_retire();
    chk("sub_busy", 64'(busy), 64'h0);

    // SRL with src1 bypassed from the CDB in the issue cycle
    push(3'd0, 64'h4);
    cdb_valid = 1'b1; cdb_rs_id = 3'd6; cdb_result = 64'h40;
    do_issue(3'd6, 1'b0, 3'd6, 64'd0, 1'b1, 3'd0, 64'd4, 3'd0);
    cdb_valid = 1'b0;
    chk("srl_wait_valid", 64'(result_valid), 64'd0);
    cyc();
    chk("srl_valid", 64'(result_valid), 64'd1);
    do_retire();

    // Fill all four entries waiting on tag 7
    for (int i = 0; i < 4; i++) begin
      push(3'(i), fill_exp[i]);
      do_issue(fill_op[i], 1'b0, 3'd7, 64'd0, 1'b1, 3'd0, fill_v2[i], 3'(i));
    end
    chk("full_ready", 64'(issue_ready), 64'd0);
    chk("full_busy", 64'(busy), 64'hF);
    issue_valid = 1'b1; issue_op = 3'd0;
    issue_src1_ready = 1'b1; issue_src1_value = 64'd99;
    issue_src2_ready = 1'b1; issue_src2_value = 64'd1;
    cyc();
    issue_valid = 1'b0;
    chk("full_ignored_busy", 64'(busy), 64'hF);
    chk("full_ignored_valid", 64'(result_valid), 64'd0);
    cdb_valid = 1'b1; cdb_rs_id = 3'd7; cdb_result = 64'h1000;
    cyc();
    cdb_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_valid("fill");
      do_retire();
      exp_busy = 4'hF << (k + 1);
      chk("fill_free_order", 64'(busy), 64'(exp_busy));
    end

    // Long hold with a second ready entry, then reset mid-hold
    push(3'd0, 64'd3);
    push(3'd1, 64'h30);
    do_issue(3'd0, 1'b1, 3'd0, 64'd1, 1'b1, 3'd0, 64'd2, 3'd0);
    do_issue(3'd2, 1'b1, 3'd0, 64'hF0, 1'b1, 3'd0, 64'h3C, 3'd1);
    wait_valid("hold");
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk("hold_valid", 64'(result_valid), 64'd1);
      chk("hold_result", result, 64'd3);
      chk("hold_rs_id", 64'(result_rs_id), 64'd0);
    end
    #2;
    rst = 1'b0;
    #1;
    chk("midhold_reset_valid", 64'(result_valid), 64'd0);
    chk("midhold_reset_busy", 64'(busy), 64'h0);
    sb.delete();
    cyc();
    rst = 1'b1;
    #1;
    chk("post_reset_ready", 64'(issue_ready), 64'd1);

    // SLT -1 < 1, SLL 1 by 0x41
    push(3'd0, 64'd1);
    push(3'd1, 64'd2);
    do_issue(3'd7, 1'b1, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 3'd0, 64'd1, 3'd0);
    do_issue(3'd5, 1'b1, 3'd0, 64'd1, 1'b1, 3'd0, 64'h41, 3'd1);
    wait_valid("slt");
    do_retire();
    wait_valid("sll");
    do_retire();
    cyc();
    chk("final_busy", 64'(busy), 64'h0);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
